// File: rtl/uitpg_mode_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and the mode-advance helper for the
// uitpg pattern scheduler.
package uitpg_mode_ctrl_pkg;

    localparam int DEF_NUM_MODES = 16;

    localparam logic [1:0] OP_RUN   = 2'd0;
    localparam logic [1:0] OP_PAUSE = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_FORCE = 2'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    // Next pattern in sequence, wrapping from num_modes-1 back to 0.
    function automatic logic [3:0] next_mode(input logic [3:0] mode, input int num_modes);
        return (int'(mode) == num_modes - 1) ? 4'd0 : mode + 4'd1;
    endfunction

endpackage

// File: rtl/uitpg_mode_ctrl_vs_edge.sv
// VS rising-edge detector: one registered copy of VS, combinational frame-start pulse.
module uitpg_vs_edge (
    input  logic clk,
    input  logic rstn,
    input  logic vs,
    output logic fs
);

    logic vs_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vs_reg <= 1'b0;
        end else begin
            vs_reg <= vs;
        end
    end

    assign fs = vs & ~vs_reg;

endmodule

// File: rtl/uitpg_mode_ctrl.sv
// Frame-synchronous pattern scheduler: auto-cycles the uitpg mode or obeys host
// RUN/PAUSE/STEP/FORCE commands, applying every change only at frame start.
module uitpg_mode_ctrl
    import uitpg_mode_ctrl_pkg::*;
#(
    parameter int NUM_MODES   = DEF_NUM_MODES,
    parameter int HOLD_FRAMES = 128,
    parameter int FCNT_W      = 16
) (
    input  logic              tpg_clk_i,
    input  logic              tpg_rstn_i,
    input  logic              tpg_vs_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [3:0]        cmd_mode_i,
    output logic [3:0]        mode_o,
    output logic              mode_stb_o,
    output logic              paused_o,
    output logic              cmd_err_o,
    output logic [FCNT_W-1:0] frame_cnt_o
);

    localparam int HOLD_W = 16;

    logic              fs;
    logic              accept;
    state_t            state_reg;
    logic [3:0]        mode_reg;
    logic              stb_reg;
    logic              err_reg;
    logic              ready_reg;
    logic [FCNT_W-1:0] fcnt_reg;
    logic [HOLD_W-1:0] hold_reg;
    logic [1:0]        pend_op_reg;
    logic [3:0]        pend_mode_reg;
    logic              pend_bad_reg;

    uitpg_vs_edge u_vs_edge (
        .clk  (tpg_clk_i),
        .rstn (tpg_rstn_i),
        .vs   (tpg_vs_i),
        .fs   (fs)
    );

    // The pending slot is occupied exactly while ready is low, so an accept and an
    // execution can never coincide, and a same-cycle accept waits for the next fs.
    assign accept = cmd_valid_i & ready_reg;

    always_ff @(posedge tpg_clk_i) begin
        if (!tpg_rstn_i) begin
            state_reg     <= ST_RUN;
            mode_reg      <= 4'd0;
            stb_reg       <= 1'b0;
            err_reg       <= 1'b0;
            ready_reg     <= 1'b1;
            fcnt_reg      <= '0;
            hold_reg      <= '0;
            pend_op_reg   <= OP_RUN;
            pend_mode_reg <= 4'd0;
            pend_bad_reg  <= 1'b0;
        end else begin
            stb_reg <= 1'b0;
            err_reg <= 1'b0;

            if (accept) begin
                pend_op_reg   <= cmd_op_i;
                pend_mode_reg <= cmd_mode_i;
                pend_bad_reg  <= (int'(cmd_mode_i) >= NUM_MODES);
                ready_reg     <= 1'b0;
            end

            if (fs) begin
                fcnt_reg <= fcnt_reg + FCNT_W'(1);
                if (!ready_reg) begin
                    // A pending command replaces the auto-advance for this frame.
                    ready_reg <= 1'b1;
                    case (pend_op_reg)
                        OP_RUN: begin
                            state_reg <= ST_RUN;
                            hold_reg  <= '0;
                        end
                        OP_PAUSE: begin
                            state_reg <= ST_PAUSE;
                        end
                        OP_STEP: begin
                            mode_reg  <= next_mode(mode_reg, NUM_MODES);
                            stb_reg   <= 1'b1;
                            state_reg <= ST_PAUSE;
                            hold_reg  <= '0;
                        end
                        default: begin
                            if (pend_bad_reg) begin
                                err_reg <= 1'b1;
                            end else begin
                                mode_reg <= pend_mode_reg;
                                stb_reg  <= (pend_mode_reg != mode_reg);
                                hold_reg <= '0;
                            end
                        end
                    endcase
                end else if (state_reg == ST_RUN) begin
                    if (hold_reg == HOLD_W'(HOLD_FRAMES - 1)) begin
                        hold_reg <= '0;
                        mode_reg <= next_mode(mode_reg, NUM_MODES);
                        stb_reg  <= 1'b1;
                    end else begin
                        hold_reg <= hold_reg + HOLD_W'(1);
                    end
                end
            end
        end
    end

    assign cmd_ready_o = ready_reg;
    assign mode_o      = mode_reg;
    assign mode_stb_o  = stb_reg;
    assign paused_o    = (state_reg == ST_PAUSE);
    assign cmd_err_o   = err_reg;
    assign frame_cnt_o = fcnt_reg;

endmodule

// File: tb/tb_uitpg_mode_ctrl.sv
// Scoreboard bench: dut1 (16 modes, hold 2) is checked frame by frame, dut2 (8 modes)
// is checked on every mode-strobe / error event.
module tb_uitpg_mode_ctrl;
    import uitpg_mode_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        vs;
    logic        v1, v2;
    logic [1:0]  op1, op2;
    logic [3:0]  m1, m2;
    logic        rdy1, stb1, paused1, err1;
    logic        rdy2, stb2, paused2, err2;
    logic [3:0]  mode1, mode2;
    logic [15:0] fcnt1, fcnt2;

    uitpg_mode_ctrl #(.NUM_MODES(16), .HOLD_FRAMES(2), .FCNT_W(16)) dut1 (
        .tpg_clk_i   (clk),
        .tpg_rstn_i  (rstn),
        .tpg_vs_i    (vs),
        .cmd_valid_i (v1),
        .cmd_ready_o (rdy1),
        .cmd_op_i    (op1),
        .cmd_mode_i  (m1),
        .mode_o      (mode1),
        .mode_stb_o  (stb1),
        .paused_o    (paused1),
        .cmd_err_o   (err1),
        .frame_cnt_o (fcnt1)
    );

    uitpg_mode_ctrl #(.NUM_MODES(8), .HOLD_FRAMES(1000), .FCNT_W(16)) dut2 (
        .tpg_clk_i   (clk),
        .tpg_rstn_i  (rstn),
        .tpg_vs_i    (vs),
        .cmd_valid_i (v2),
        .cmd_ready_o (rdy2),
        .cmd_op_i    (op2),
        .cmd_mode_i  (m2),
        .mode_o      (mode2),
        .mode_stb_o  (stb2),
        .paused_o    (paused2),
        .cmd_err_o   (err2),
        .frame_cnt_o (fcnt2)
    );

    typedef struct packed {
        logic [3:0]  mode;
        logic        stb;
        logic        paused;
        logic        err;
        logic        ready;
        logic [15:0] fcnt;
    } frame_t;

    typedef struct packed {
        logic       stb;
        logic       err;
        logic [3:0] mode;
        logic       ready;
    } evt_t;

    frame_t fq[$];
    evt_t   eq[$];
    int     n_chk  = 0;
    int     n_fail = 0;

    function automatic frame_t fr(input logic [3:0] m, input logic s, input logic p,
                                  input logic e, input logic r, input int f);
        return '{mode: m, stb: s, paused: p, err: e, ready: r, fcnt: 16'(f)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Independent frame-start tracker: results are visible on the negedge after the fs edge.
    logic vs_prev  = 1'b0;
    logic fs_seen  = 1'b0;
    always @(posedge clk) begin
        fs_seen <= rstn & vs & ~vs_prev;
        vs_prev <= rstn ? vs : 1'b0;
    end

    frame_t got_f, exp_f;
    evt_t   got_e, exp_e;

    always @(negedge clk) begin
        if (fs_seen) begin
            got_f = '{mode: mode1, stb: stb1, paused: paused1, err: err1, ready: rdy1, fcnt: fcnt1};
            n_chk++;
            if (fq.size() == 0) begin
                n_fail++;
                $display("FAIL dut1_frame: unexpected frame, got mode=%0d fcnt=%0d", mode1, fcnt1);
            end else begin
                exp_f = fq.pop_front();
                if (got_f !== exp_f) begin
                    n_fail++;
                    $display("FAIL dut1_frame%0d: got mode=%0d stb=%0b paused=%0b err=%0b ready=%0b fcnt=%0d, expected mode=%0d stb=%0b paused=%0b err=%0b ready=%0b fcnt=%0d",
                             exp_f.fcnt, got_f.mode, got_f.stb, got_f.paused, got_f.err, got_f.ready, got_f.fcnt,
                             exp_f.mode, exp_f.stb, exp_f.paused, exp_f.err, exp_f.ready, exp_f.fcnt);
                end else begin
                    $display("dut1 frame %0d ok: mode=%0d stb=%0b paused=%0b ready=%0b",
                             got_f.fcnt, got_f.mode, got_f.stb, got_f.paused, got_f.ready);
                end
            end
        end
        if (stb2 | err2) begin
            got_e = '{stb: stb2, err: err2, mode: mode2, ready: rdy2};
            n_chk++;
            if (eq.size() == 0) begin
                n_fail++;
                $display("FAIL dut2_event: unexpected event, got stb=%0b err=%0b mode=%0d", stb2, err2, mode2);
            end else begin
                exp_e = eq.pop_front();
                if (got_e !== exp_e) begin
                    n_fail++;
                    $display("FAIL dut2_event: got stb=%0b err=%0b mode=%0d ready=%0b, expected stb=%0b err=%0b mode=%0d ready=%0b",
                             got_e.stb, got_e.err, got_e.mode, got_e.ready,
                             exp_e.stb, exp_e.err, exp_e.mode, exp_e.ready);
                end else begin
                    $display("dut2 event ok: stb=%0b err=%0b mode=%0d", got_e.stb, got_e.err, got_e.mode);
                end
            end
        end
    end

    task automatic frame(input frame_t e);
        fq.push_back(e);
        @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // VS rises in the same cycle the command is presented to dut1.
    task automatic frame_cmd(input frame_t e, input logic [1:0] op, input logic [3:0] m);
        fq.push_back(e);
        @(negedge clk);
        vs = 1'b1;
        v1 = 1'b1; op1 = op; m1 = m;
        @(negedge clk);
        vs = 1'b0;
        v1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cmd(input int d, input logic [1:0] op, input logic [3:0] m);
        @(negedge clk);
        if (d == 1) begin
            v1 = 1'b1; op1 = op; m1 = m;
        end else begin
            v2 = 1'b1; op2 = op; m2 = m;
        end
        @(negedge clk);
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; vs = 1'b0;
        v1 = 1'b0; op1 = OP_RUN; m1 = 4'd0;
        v2 = 1'b0; op2 = OP_RUN; m2 = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_mode", 32'(mode1), 32'd0);
        check("reset_ready", 32'(rdy1), 32'd1);
        check("reset_fcnt", 32'(fcnt1), 32'd0);
        check("reset_paused", 32'(paused1), 32'd0);
        rstn = 1'b1;

        // Auto-cycle with a 2-frame hold.
        frame(fr(0, 0, 0, 0, 1, 1));
        frame(fr(1, 1, 0, 0, 1, 2));
        frame(fr(1, 0, 0, 0, 1, 3));
        frame(fr(2, 1, 0, 0, 1, 4));
        frame(fr(2, 0, 0, 0, 1, 5));
        check("stb_one_cycle", 32'(stb1), 32'd0);

        // PAUSE mid-frame; dut2 gets illegal / top-legal / just-illegal FORCEs meanwhile.
        cmd(1, OP_PAUSE, 4'd0);
        check("pause_ready_drop", 32'(rdy1), 32'd0);
        check("pause_not_yet", 32'(paused1), 32'd0);
        frame(fr(2, 0, 1, 0, 1, 6));
        cmd(2, OP_FORCE, 4'd12);
        check("d2_ready_drop", 32'(rdy2), 32'd0);
        eq.push_back('{stb: 1'b0, err: 1'b1, mode: 4'd0, ready: 1'b1});
        frame(fr(2, 0, 1, 0, 1, 7));
        check("d2_err_one_cycle", 32'(err2), 32'd0);
        cmd(2, OP_FORCE, 4'd7);
        eq.push_back('{stb: 1'b1, err: 1'b0, mode: 4'd7, ready: 1'b1});
        frame(fr(2, 0, 1, 0, 1, 8));
        cmd(2, OP_FORCE, 4'd8);
        eq.push_back('{stb: 1'b0, err: 1'b1, mode: 4'd7, ready: 1'b1});
        frame(fr(2, 0, 1, 0, 1, 9));
        frame(fr(2, 0, 1, 0, 1, 10));

        // Paused at 15, STEP wraps to 0, RUN restarts a full hold.
        cmd(1, OP_FORCE, 4'd15);
        frame(fr(15, 1, 1, 0, 1, 11));
        cmd(1, OP_STEP, 4'd0);
        frame(fr(0, 1, 1, 0, 1, 12));
        cmd(1, OP_RUN, 4'd0);
        frame(fr(0, 0, 0, 0, 1, 13));
        frame(fr(0, 0, 0, 0, 1, 14));
        frame(fr(1, 1, 0, 0, 1, 15));

        // FORCE accepted on the fs cycle waits a frame; a command while busy is dropped.
        frame_cmd(fr(1, 0, 0, 0, 0, 16), OP_FORCE, 4'd9);
        cmd(1, OP_FORCE, 4'd3);
        check("busy_cmd_ignored", 32'(rdy1), 32'd0);
        frame(fr(9, 1, 0, 0, 1, 17));
        frame(fr(9, 0, 0, 0, 1, 18));
        cmd(1, OP_FORCE, 4'd9);
        frame(fr(9, 0, 0, 0, 1, 19));
        frame(fr(9, 0, 0, 0, 1, 20));

        // One-clock reset with a PAUSE pending at mode 5.
        cmd(1, OP_FORCE, 4'd5);
        frame(fr(5, 1, 0, 0, 1, 21));
        cmd(1, OP_PAUSE, 4'd0);
        check("pend_before_reset", 32'(rdy1), 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("rst2_mode", 32'(mode1), 32'd0);
        check("rst2_stb", 32'(stb1), 32'd0);
        check("rst2_paused", 32'(paused1), 32'd0);
        check("rst2_err", 32'(err1), 32'd0);
        check("rst2_fcnt", 32'(fcnt1), 32'd0);
        check("rst2_ready", 32'(rdy1), 32'd1);
        check("rst2_d2_mode", 32'(mode2), 32'd0);
        rstn = 1'b1;
        frame(fr(0, 0, 0, 0, 1, 1));
        frame(fr(1, 1, 0, 0, 1, 2));

        repeat (4) @(negedge clk);
        check("dut1_queue_drained", 32'(fq.size()), 32'd0);
        check("dut2_queue_drained", 32'(eq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
